// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry and the
// address of the optional hardwired zero register.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave):
// read ports, write ports and the scoreboard set request.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// One read port: forwards same-cycle write data (highest write port wins),
// masks the busy bit on a forward, and forces zero for reset / register 0.
module regfile_mp_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        base_data,
  input  logic                     base_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  logic              hit;
  logic [DATA_W-1:0] fwd;

  always_comb begin
    // NOTE: defaults first so every path assigns hit/fwd; a missing default infers a latch.
    hit = 1'b0;
    fwd = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (BYPASS != 0 && wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == rd_addr) begin
        hit = 1'b1;
        fwd = wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data = hit ? fwd : base_data;
    rd_busy = base_busy & ~hit;
    if (rst || (ZERO_REG != 0 && rd_addr == ADDR_W'(REG_ZERO))) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register, write-to-read
// bypass and a per-register busy scoreboard (set in ID, cleared by WB writes).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is flops, not a RAM macro, so clearing every entry on reset is legal here.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments; the last one in program order wins, which gives
      // the higher write port priority and lets a scoreboard set override a clear.
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j]) begin
          if (!(ZERO_REG != 0 && bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)))
            mem[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
          busy[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (bus.sb_set_en) busy[bus.sb_set_addr] <= 1'b1;
      if (ZERO_REG != 0) busy[REG_ZERO] <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy_bit;

    assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

    regfile_mp_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .rst       (rst),
      .rd_addr   (addr),
      .base_data (mem[addr]),
      .base_busy (busy[addr]),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .rd_data   (data),
      .rd_busy   (busy_bit)
    );

    assign bus.rd_data[i*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[i]                  = busy_bit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench: two register files (bypass+zero reg, and plain) on shared stimulus,
// checked against a reference model through an expected-value queue.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_a ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus_b ();

  assign bus_b.rd_addr     = bus_a.rd_addr;
  assign bus_b.wr_en       = bus_a.wr_en;
  assign bus_b.wr_addr     = bus_a.wr_addr;
  assign bus_b.wr_data     = bus_a.wr_data;
  assign bus_b.sb_set_en   = bus_a.sb_set_en;
  assign bus_b.sb_set_addr = bus_a.sb_set_addr;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Stimulus for the current cycle.
  logic          s_rst;
  logic [NW-1:0] s_wr_en;
  logic [AW-1:0] s_wr_addr [NW];
  logic [DW-1:0] s_wr_data [NW];
  logic          s_sb_en;
  logic [AW-1:0] s_sb_addr;
  logic [AW-1:0] s_rd_addr [NR];

  // Reference state; index 0 models dut_a (zero reg + bypass), index 1 models dut_b.
  logic [DW-1:0]    m_mem  [2][DEPTH];
  logic [DEPTH-1:0] m_busy [2];

  typedef struct packed {
    logic [NR*DW-1:0] data_a;
    logic [NR*DW-1:0] data_b;
    logic [NR-1:0]    busy_a;
    logic [NR-1:0]    busy_b;
  } exp_t;

  exp_t  sb_q [$];
  int    checks = 0;
  int    errors = 0;
  string tag    = "init";

  function automatic void model_read(input int c, output logic [NR*DW-1:0] d,
                                     output logic [NR-1:0] b);
    bit            zr;
    logic [AW-1:0] a;
    logic [DW-1:0] dv;
    logic          bv;
    zr = (c == 0);
    for (int i = 0; i < NR; i++) begin
      a  = s_rd_addr[i];
      dv = m_mem[c][a];
      bv = m_busy[c][a];
      if (c == 0) begin
        for (int j = 0; j < NW; j++) begin
          if (s_wr_en[j] && s_wr_addr[j] == a) begin
            dv = s_wr_data[j];
            bv = 1'b0;
          end
        end
      end
      if (s_rst || (zr && a == '0)) begin
        dv = '0;
        bv = 1'b0;
      end
      d[i*DW +: DW] = dv;
      b[i]          = bv;
    end
  endfunction

  function automatic void model_update(input int c);
    if (s_rst) begin
      for (int k = 0; k < DEPTH; k++) m_mem[c][k] = '0;
      m_busy[c] = '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (s_wr_en[j]) begin
          if (!(c == 0 && s_wr_addr[j] == '0)) m_mem[c][s_wr_addr[j]] = s_wr_data[j];
          m_busy[c][s_wr_addr[j]] = 1'b0;
        end
      end
      if (s_sb_en) m_busy[c][s_sb_addr] = 1'b1;
      if (c == 0) m_busy[c][0] = 1'b0;
    end
  endfunction

  task automatic idle();
    s_rst     = 1'b0;
    s_wr_en   = '0;
    s_sb_en   = 1'b0;
    s_sb_addr = '0;
    for (int j = 0; j < NW; j++) begin
      s_wr_addr[j] = '0;
      s_wr_data[j] = '0;
    end
    for (int i = 0; i < NR; i++) s_rd_addr[i] = '0;
  endtask

  // Apply stimulus, push the model's prediction, let outputs settle, pop and compare.
  task automatic drive();
    exp_t e;
    rst             = s_rst;
    bus_a.wr_en     = s_wr_en;
    bus_a.sb_set_en = s_sb_en;
    bus_a.sb_set_addr = s_sb_addr;
    for (int j = 0; j < NW; j++) begin
      bus_a.wr_addr[j*AW +: AW] = s_wr_addr[j];
      bus_a.wr_data[j*DW +: DW] = s_wr_data[j];
    end
    for (int i = 0; i < NR; i++) bus_a.rd_addr[i*AW +: AW] = s_rd_addr[i];
    model_read(0, e.data_a, e.busy_a);
    model_read(1, e.data_b, e.busy_b);
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    checks++;
    if (bus_a.rd_data !== e.data_a) begin
      errors++;
      $display("FAIL %s rd_data_a: got %h expected %h", tag, bus_a.rd_data, e.data_a);
    end
    checks++;
    if (bus_a.rd_busy !== e.busy_a) begin
      errors++;
      $display("FAIL %s rd_busy_a: got %b expected %b", tag, bus_a.rd_busy, e.busy_a);
    end
    checks++;
    if (bus_b.rd_data !== e.data_b) begin
      errors++;
      $display("FAIL %s rd_data_b: got %h expected %h", tag, bus_b.rd_data, e.data_b);
    end
    checks++;
    if (bus_b.rd_busy !== e.busy_b) begin
      errors++;
      $display("FAIL %s rd_busy_b: got %b expected %b", tag, bus_b.rd_busy, e.busy_b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic test_reset();
    tag = "reset";
    idle();
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd3; s_wr_data[0] = 32'hDEAD;
    s_sb_en = 1'b1;  s_sb_addr    = 5'd3;
    drive(); tick();
    idle(); s_rd_addr[0] = 5'd3;
    drive();
    checks++;
    if (bus_a.rd_data[0 +: DW] !== 32'hDEAD || bus_a.rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: got %h/%b expected 0000dead/1", bus_a.rd_data[0 +: DW], bus_a.rd_busy[0]);
    end
    s_rst = 1'b1;
    drive();
    checks++;
    if (bus_a.rd_data !== '0 || bus_a.rd_busy !== '0 || bus_b.rd_data !== '0 || bus_b.rd_busy !== '0) begin
      errors++;
      $display("FAIL reset_during: got %h/%b expected all zero", bus_a.rd_data, bus_a.rd_busy);
    end
    tick();
    s_rst = 1'b0;
    drive();
    checks++;
    if (bus_a.rd_data[0 +: DW] !== '0 || bus_a.rd_busy[0] !== 1'b0 || bus_b.rd_data[0 +: DW] !== '0) begin
      errors++;
      $display("FAIL reset_after: got %h/%b expected 0/0", bus_a.rd_data[0 +: DW], bus_a.rd_busy[0]);
    end
    tick();
  endtask

  task automatic test_bypass();
    tag = "bypass";
    idle();
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd5; s_wr_data[0] = 32'h1234; s_rd_addr[0] = 5'd5;
    drive();
    checks++;
    if (bus_a.rd_data[0 +: DW] !== 32'h1234 || bus_b.rd_data[0 +: DW] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_same: got a=%h b=%h expected 1234/0", bus_a.rd_data[0 +: DW], bus_b.rd_data[0 +: DW]);
    end
    tick();
    idle(); s_rd_addr[0] = 5'd5;
    drive();
    checks++;
    if (bus_b.rd_data[0 +: DW] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_next: got %h expected 1234", bus_b.rd_data[0 +: DW]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    tag = "zero_reg";
    idle();
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd0; s_wr_data[0] = 32'hFFFF_FFFF;
    s_sb_en = 1'b1;  s_sb_addr = 5'd0;
    drive();
    checks++;
    if (bus_a.rd_data !== '0 || bus_a.rd_busy !== '0) begin
      errors++;
      $display("FAIL zero_same: got %h/%b expected 0/0", bus_a.rd_data, bus_a.rd_busy);
    end
    tick();
    idle();
    drive();
    checks++;
    if (bus_a.rd_data !== '0 || bus_a.rd_busy !== '0) begin
      errors++;
      $display("FAIL zero_next: got %h/%b expected 0/0", bus_a.rd_data, bus_a.rd_busy);
    end
    checks++;
    if (bus_b.rd_data[0 +: DW] !== 32'hFFFF_FFFF || bus_b.rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_plain: got %h/%b expected ffffffff/1", bus_b.rd_data[0 +: DW], bus_b.rd_busy[0]);
    end
    tick();
  endtask

  task automatic test_conflict();
    tag = "conflict";
    idle();
    s_wr_en = 2'b11;
    s_wr_addr[0] = 5'd7; s_wr_data[0] = 32'hA;
    s_wr_addr[1] = 5'd7; s_wr_data[1] = 32'hB;
    s_rd_addr[1] = 5'd7;
    drive();
    checks++;
    if (bus_a.rd_data[DW +: DW] !== 32'hB) begin
      errors++;
      $display("FAIL conflict_bypass: got %h expected b", bus_a.rd_data[DW +: DW]);
    end
    tick();
    idle(); s_rd_addr[1] = 5'd7;
    drive();
    checks++;
    if (bus_a.rd_data[DW +: DW] !== 32'hB || bus_b.rd_data[DW +: DW] !== 32'hB) begin
      errors++;
      $display("FAIL conflict_array: got a=%h b=%h expected b", bus_a.rd_data[DW +: DW], bus_b.rd_data[DW +: DW]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    tag = "scoreboard";
    idle();
    s_sb_en = 1'b1; s_sb_addr = 5'd9; s_rd_addr[2] = 5'd9;
    drive();
    checks++;
    if (bus_a.rd_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL sb_before_edge: got %b expected 0", bus_a.rd_busy[2]);
    end
    tick();
    idle(); s_rd_addr[2] = 5'd9;
    drive();
    checks++;
    if (bus_a.rd_busy[2] !== 1'b1 || bus_b.rd_busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set: got a=%b b=%b expected 1/1", bus_a.rd_busy[2], bus_b.rd_busy[2]);
    end
    s_wr_en = 2'b10; s_wr_addr[1] = 5'd9; s_wr_data[1] = 32'h55;
    drive();
    checks++;
    if (bus_a.rd_busy[2] !== 1'b0 || bus_b.rd_busy[2] !== 1'b1 || bus_a.rd_data[2*DW +: DW] !== 32'h55) begin
      errors++;
      $display("FAIL sb_wb_cycle: got a=%b b=%b d=%h expected 0/1/55",
               bus_a.rd_busy[2], bus_b.rd_busy[2], bus_a.rd_data[2*DW +: DW]);
    end
    tick();
    idle(); s_rd_addr[2] = 5'd9;
    drive();
    checks++;
    if (bus_a.rd_busy[2] !== 1'b0 || bus_b.rd_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: got a=%b b=%b expected 0/0", bus_a.rd_busy[2], bus_b.rd_busy[2]);
    end
    s_sb_en = 1'b1; s_sb_addr = 5'd9;
    s_wr_en = 2'b01; s_wr_addr[0] = 5'd9; s_wr_data[0] = 32'h66;
    drive(); tick();
    idle(); s_rd_addr[2] = 5'd9;
    drive();
    checks++;
    if (bus_a.rd_busy[2] !== 1'b1 || bus_a.rd_data[2*DW +: DW] !== 32'h66) begin
      errors++;
      $display("FAIL sb_set_wins: got %b/%h expected 1/66", bus_a.rd_busy[2], bus_a.rd_data[2*DW +: DW]);
    end
    tick();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic test_random();
    tag = "random";
    for (int n = 0; n < 3000; n++) begin
      s_rst   = ($urandom_range(0, 63) == 0);
      s_sb_en = 1'($urandom_range(0, 1));
      s_sb_addr = rnd_addr();
      for (int j = 0; j < NW; j++) begin
        s_wr_en[j]   = 1'($urandom_range(0, 1));
        s_wr_addr[j] = rnd_addr();
        s_wr_data[j] = $urandom;
      end
      for (int i = 0; i < NR; i++) s_rd_addr[i] = rnd_addr();
      drive();
      tick();
    end
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < DEPTH; k++) m_mem[c][k] = '0;
      m_busy[c] = '0;
    end
    idle();
    s_rst = 1'b1;
    #1;
    drive(); tick();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_conflict();
    test_scoreboard();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
